// File: rtl/diffaddmul_dispatch.sv
// diffaddmul_dispatch
//   Receiving end of the subtract stage in the DiffAddMul datapath. Each
//   accepted packet is steered by a one-hot select into one of three
//   independently buffered channels: neg, add and mul. Because every channel
//   has its own FIFO, a stalled consumer only blocks packets aimed at it.
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready depends only on
//                         in_sel and registered occupancy
//   in_pcl1 [16:0]        {diff, k, op}; the same diff/k also travel in in_pcl2
//   in_pcl2 [15:0]        {diff, k}
//   in_sel  [2:0]         one-hot: 001 neg, 010 add, 100 mul
//   neg_valid/ready/data  neg channel head, data = two's-complement negate of diff
//   add_valid/ready/data  add channel head, data = {diff, k}
//   mul_valid/ready/data  mul channel head, data = {diff, k}
//   pkt_cnt               packets written into any FIFO, wraps
//   err_sel               sticky: a non-one-hot packet was accepted and dropped
module diffaddmul_dispatch #(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16:0]     in_pcl1,
  input  logic [15:0]     in_pcl2,
  input  logic [2:0]      in_sel,
  output logic            neg_valid,
  input  logic            neg_ready,
  output logic [7:0]      neg_data,
  output logic            add_valid,
  input  logic            add_ready,
  output logic [15:0]     add_data,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic [15:0]     mul_data,
  output logic [CNTW-1:0] pkt_cnt,
  output logic            err_sel
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [2:0]  full;
  logic [2:0]  push;
  logic [2:0]  pop;
  logic [2:0]  cons_ready;
  logic [2:0]  head_valid;
  logic [15:0] push_data [3];
  logic [15:0] head_data [3];
  logic [7:0]  neg_mag;
  logic        sel_ok;
  logic        accept;

  assign sel_ok     = (in_sel == 3'b001) || (in_sel == 3'b010) || (in_sel == 3'b100);
  assign cons_ready = {mul_ready, add_ready, neg_ready};

  // A bad select is always taken (and dropped) so upstream never deadlocks.
  // The full check uses registered occupancy only: a same-cycle pop does not
  // open a slot, which keeps in_ready free of any consumer-ready path.
  assign in_ready = sel_ok ? |(in_sel & ~full) : 1'b1;
  assign accept   = in_valid && in_ready;
  assign push     = (accept && sel_ok) ? in_sel : 3'b000;

  assign neg_mag      = ~in_pcl2[15:8] + 8'd1;
  assign push_data[0] = {8'h00, neg_mag};
  assign push_data[1] = in_pcl2;
  assign push_data[2] = in_pcl2;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [15:0]   mem [DEPTH];
      logic [AW-1:0] rd_ptr_reg;
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_next;
      logic [AW:0]   count_reg;
      logic [AW:0]   kept;
      logic [AW:0]   count_next;
      logic [15:0]   data_reg;
      logic          valid_reg;

      assign pop[gi]  = valid_reg && cons_ready[gi];
      assign full[gi] = (count_reg == DEPTH_C);

      assign rd_ptr_next = rd_ptr_reg + AW'(pop[gi]);
      assign kept        = count_reg - (AW+1)'(pop[gi]);
      assign count_next  = kept + (AW+1)'(push[gi]);

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wr_ptr_reg] <= push_data[gi];
        end
      end

      // The head is a register of its own. If nothing older survives this
      // cycle's pop, the new head is the word being pushed; otherwise it is
      // an entry already stored at the advanced read pointer. When the FIFO
      // drains, data_reg keeps its last value.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          data_reg   <= '0;
          valid_reg  <= 1'b0;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + AW'(push[gi]);
          rd_ptr_reg <= rd_ptr_next;
          count_reg  <= count_next;
          valid_reg  <= (count_next != '0);
          if (count_next != '0) begin
            data_reg <= (kept == '0) ? push_data[gi] : mem[rd_ptr_next];
          end
        end
      end

      assign head_valid[gi] = valid_reg;
      assign head_data[gi]  = data_reg;
    end
  endgenerate

  assign neg_valid = head_valid[0];
  assign neg_data  = head_data[0][7:0];
  assign add_valid = head_valid[1];
  assign add_data  = head_data[1];
  assign mul_valid = head_valid[2];
  assign mul_data  = head_data[2];

  // in_pcl1 duplicates diff/k from in_pcl2; op is not needed by the dispatcher.
  logic unused_bits;
  assign unused_bits = ^{in_pcl1, head_data[0][15:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
      err_sel <= 1'b0;
    end else begin
      if (push != 3'b000) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (accept && !sel_ok) begin
        err_sel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_diffaddmul_dispatch.sv
// Directed and random checks for diffaddmul_dispatch (DEPTH = 2, CNTW = 16).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_diffaddmul_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_pcl1;
  logic [15:0] in_pcl2;
  logic [2:0]  in_sel;
  logic        neg_valid, neg_ready;
  logic [7:0]  neg_data;
  logic        add_valid, add_ready;
  logic [15:0] add_data;
  logic        mul_valid, mul_ready;
  logic [15:0] mul_data;
  logic [15:0] pkt_cnt;
  logic        err_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  diffaddmul_dispatch #(.DEPTH(2), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pcl1(in_pcl1), .in_pcl2(in_pcl2), .in_sel(in_sel),
    .neg_valid(neg_valid), .neg_ready(neg_ready), .neg_data(neg_data),
    .add_valid(add_valid), .add_ready(add_ready), .add_data(add_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_data(mul_data),
    .pkt_cnt(pkt_cnt), .err_sel(err_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] sel, input logic [15:0] p2);
    in_valid = 1'b1;
    in_sel   = sel;
    in_pcl2  = p2;
    in_pcl1  = {p2, 1'b0};
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sel = 3'b000; in_pcl1 = '0; in_pcl2 = '0;
    neg_ready = 1'b0; add_ready = 1'b0; mul_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({neg_valid, add_valid, mul_valid, err_sel} !== 4'b0000 || pkt_cnt !== 16'd0 ||
        neg_data !== 8'h00 || add_data !== 16'h0 || mul_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: valids=%b err=%b cnt=%0d data=%h/%h/%h required all zero",
               {neg_valid, add_valid, mul_valid}, err_sel, pkt_cnt, neg_data, add_data, mul_data);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_neg();
    do_reset();
    neg_ready = 1'b1;
    present(3'b001, 16'hE005);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL neg_ready_in: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++;
    if (neg_valid !== 1'b1 || neg_data !== 8'h20 || pkt_cnt !== 16'd1) begin
      fails++;
      $display("FAIL neg_e0: valid=%b data=%h cnt=%0d required 1/20/1", neg_valid, neg_data, pkt_cnt);
    end
    present(3'b001, 16'h0011);
    tick();
    in_valid = 1'b0;
    tests++;
    if (neg_valid !== 1'b1 || neg_data !== 8'h00) begin
      fails++;
      $display("FAIL neg_zero: valid=%b data=%h required 1/00", neg_valid, neg_data);
    end
    tick();
    tests++;
    if (neg_valid !== 1'b0 || neg_data !== 8'h00 || pkt_cnt !== 16'd2) begin
      fails++;
      $display("FAIL neg_drain: valid=%b data=%h cnt=%0d required 0/00/2", neg_valid, neg_data, pkt_cnt);
    end
    $display("[TB] neg channel checked");
  endtask

  task automatic test_backpressure();
    do_reset();
    present(3'b010, 16'h1203); tick();
    present(3'b010, 16'h4007); tick();
    present(3'b010, 16'h9999); #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL add_full: in_ready=%b required 0", in_ready); end
    present(3'b100, 16'h5566); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL mul_indep: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++;
    if (mul_valid !== 1'b1 || mul_data !== 16'h5566 || pkt_cnt !== 16'd3) begin
      fails++;
      $display("FAIL mul_accept: valid=%b data=%h cnt=%0d required 1/5566/3", mul_valid, mul_data, pkt_cnt);
    end
    add_ready = 1'b1;
    tests++;
    if (add_valid !== 1'b1 || add_data !== 16'h1203) begin
      fails++; $display("FAIL add_first: valid=%b data=%h required 1/1203", add_valid, add_data);
    end
    tick();
    tests++;
    if (add_valid !== 1'b1 || add_data !== 16'h4007) begin
      fails++; $display("FAIL add_second: valid=%b data=%h required 1/4007", add_valid, add_data);
    end
    tick();
    tests++;
    if (add_valid !== 1'b0 || add_data !== 16'h4007) begin
      fails++; $display("FAIL add_empty: valid=%b data=%h required 0/4007", add_valid, add_data);
    end
    $display("[TB] backpressure checked");
  endtask

  task automatic test_no_bypass();
    do_reset();
    present(3'b010, 16'h1111); tick();
    present(3'b010, 16'h2222); tick();
    add_ready = 1'b1;
    present(3'b010, 16'hAAAA); #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL no_bypass: in_ready=%b required 0", in_ready); end
    tick();
    add_ready = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || add_data !== 16'h2222 || pkt_cnt !== 16'd2) begin
      fails++;
      $display("FAIL after_pop: in_ready=%b head=%h cnt=%0d required 1/2222/2", in_ready, add_data, pkt_cnt);
    end
    tick();
    in_valid = 1'b0;
    add_ready = 1'b1;
    tests++;
    if (pkt_cnt !== 16'd3 || add_data !== 16'h2222) begin
      fails++; $display("FAIL late_push: cnt=%0d head=%h required 3/2222", pkt_cnt, add_data);
    end
    tick();
    tests++;
    if (add_valid !== 1'b1 || add_data !== 16'hAAAA) begin
      fails++; $display("FAIL late_head: valid=%b data=%h required 1/AAAA", add_valid, add_data);
    end
    tick();
    $display("[TB] no-bypass checked");
  endtask

  task automatic test_bad_sel();
    do_reset();
    present(3'b011, 16'h3344); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bad_ready: in_ready=%b required 1", in_ready); end
    tick();
    present(3'b000, 16'h1234); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_sel_ready: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tick();
    tests++;
    if (err_sel !== 1'b1 || pkt_cnt !== 16'd0 || {neg_valid, add_valid, mul_valid} !== 3'b000) begin
      fails++;
      $display("FAIL bad_sel: err=%b cnt=%0d valids=%b required 1/0/000", err_sel, pkt_cnt,
               {neg_valid, add_valid, mul_valid});
    end
    $display("[TB] bad select checked");
  endtask

  task automatic test_reset_mid();
    do_reset();
    present(3'b100, 16'hABCD); tick();
    present(3'b100, 16'hBEEF); tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (mul_valid !== 1'b0 || pkt_cnt !== 16'd0 || mul_data !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b cnt=%0d data=%h required 0/0/0000", mul_valid, pkt_cnt, mul_data);
    end
    present(3'b100, 16'h7788); tick();
    in_valid = 1'b0;
    tests++;
    if (mul_valid !== 1'b1 || mul_data !== 16'h7788 || pkt_cnt !== 16'd1) begin
      fails++;
      $display("FAIL post_reset_push: valid=%b data=%h cnt=%0d required 1/7788/1", mul_valid, mul_data, pkt_cnt);
    end
    $display("[TB] mid-operation reset checked");
  endtask

  task automatic test_random();
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic [15:0] exp_w;
    logic [8:0]  neg_w;
    int  accepted = 0;
    int  n;
    logic hold = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 10000 + 20; cyc++) begin
      neg_ready = 1'($urandom_range(0, 1));
      add_ready = 1'($urandom_range(0, 1));
      mul_ready = 1'($urandom_range(0, 1));
      if (!hold) begin
        if (cyc < 10000 && $urandom_range(0, 3) != 0) begin
          n = $urandom_range(0, 2);
          present(3'b001 << n, 16'($urandom));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (cyc >= 10000) begin
        neg_ready = 1'b1; add_ready = 1'b1; mul_ready = 1'b1;
      end
      #1;
      // Pops at this edge: compare heads against model order.
      if (neg_valid && neg_ready) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL rnd_neg_extra: data=%h required none", neg_data); end
        else begin
          exp_w = q0.pop_front();
          if (neg_data !== exp_w[7:0]) begin fails++; $display("FAIL rnd_neg: data=%h required %h", neg_data, exp_w[7:0]); end
        end
      end
      if (add_valid && add_ready) begin
        tests++;
        if (q1.size() == 0) begin fails++; $display("FAIL rnd_add_extra: data=%h required none", add_data); end
        else begin
          exp_w = q1.pop_front();
          if (add_data !== exp_w) begin fails++; $display("FAIL rnd_add: data=%h required %h", add_data, exp_w); end
        end
      end
      if (mul_valid && mul_ready) begin
        tests++;
        if (q2.size() == 0) begin fails++; $display("FAIL rnd_mul_extra: data=%h required none", mul_data); end
        else begin
          exp_w = q2.pop_front();
          if (mul_data !== exp_w) begin fails++; $display("FAIL rnd_mul: data=%h required %h", mul_data, exp_w); end
        end
      end
      if (in_valid) begin
        // Occupancy before popping at this edge decides readiness.
        logic exp_rdy;
        case (in_sel)
          3'b001:  exp_rdy = (q0.size() + ((neg_valid && neg_ready) ? 1 : 0)) < 2;
          3'b010:  exp_rdy = (q1.size() + ((add_valid && add_ready) ? 1 : 0)) < 2;
          default: exp_rdy = (q2.size() + ((mul_valid && mul_ready) ? 1 : 0)) < 2;
        endcase
        tests++;
        if (in_ready !== exp_rdy) begin
          fails++; $display("FAIL rnd_in_ready: cyc=%0d sel=%b in_ready=%b required %b", cyc, in_sel, in_ready, exp_rdy);
        end
        if (in_ready) begin
          accepted++;
          neg_w = 9'h100 - {1'b0, in_pcl2[15:8]};
          case (in_sel)
            3'b001:  q0.push_back({8'h00, neg_w[7:0]});
            3'b010:  q1.push_back(in_pcl2);
            default: q2.push_back(in_pcl2);
          endcase
        end
      end
      hold = in_valid && !in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tests++;
    if (q0.size() + q1.size() + q2.size() != 0 || neg_valid || add_valid || mul_valid) begin
      fails++;
      $display("FAIL rnd_loss: left=%0d/%0d/%0d valids=%b required empty", q0.size(), q1.size(), q2.size(),
               {neg_valid, add_valid, mul_valid});
    end
    tests++;
    if (pkt_cnt !== 16'(accepted)) begin
      fails++; $display("FAIL rnd_pkt_cnt: cnt=%0d required %0d", pkt_cnt, accepted);
    end
    $display("[TB] random traffic: %0d packets accepted", accepted);
  endtask

  initial begin
    test_reset();
    test_neg();
    test_backpressure();
    test_no_bypass();
    test_bad_sel();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
